systolic_skew_feeder: RTL
=========================

Name: systolic_skew_feeder

Overview:
- Loads one FP8 (E4M3) operand tile pair, A (N rows x K) and B (K x N, supplied as columns), through a valid/ready input.
- Replays the tile into the west (a_in) and north (b_in) edges of an N x N systolic array of MXFP8 MAC PEs with diagonal skew.
- Issues the array-wide accumulator clear and reports when the BF16 results at the PE c_out ports are final.
- Sits directly upstream of the PE array.

Parameters:
- N, 2, array dimension (rows = columns = edge lanes).
- K, 2, reduction depth (elements per A row / B column).
- PE_LATENCY, 3, cycles from PE input capture to final c_out update (decode, accumulate, BF16 register).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-low: rst==0 at a rising edge resets the block.
- in_valid  in  1  load beat valid.
- in_ready  out  1  block accepts a load beat.
- in_data  in  8*K  one A row or one B column. Element k is at [8k+7:8k].
- a_edge  out  8*N  west-edge bytes. Lane i at [8i+7:8i] drives PE row i a_in.
- b_edge  out  8*N  north-edge bytes. Lane j drives PE column j b_in.
- clear  out  1  one-cycle accumulator clear to all PEs.
- busy  out  1  high in CLEAR, STREAM, DRAIN and DONE.
- tile_done  out  1  one-cycle pulse: every PE c_out holds the final tile result.

Behaviour:
- All outputs are registered.
- Reset values: in_ready=0, a_edge=0, b_edge=0, clear=0, busy=0, tile_done=0. State becomes LOAD_A and all counters are zeroed.
- Reset asserted mid-operation aborts the tile. Buffered data is discarded.
- States and transitions:
  - LOAD_A → LOAD_B after N handshakes. A handshake is in_valid && in_ready. Beat r is stored as A row r.
  - LOAD_B → CLEAR after N handshakes. Beat c is stored as B column c.
  - CLEAR → STREAM after 1 cycle.
  - STREAM → DRAIN after K+N-1 cycles.
  - DRAIN → DONE after N-1+PE_LATENCY cycles.
  - DONE → LOAD_A after 1 cycle.
- in_ready is high exactly in LOAD_A and LOAD_B. It first rises the cycle after rst deasserts.
- in_valid outside the load states is ignored. in_data is not required to be held.
- Timing, with L the cycle of the final LOAD_B handshake:
  - clear is high in cycle C = L+1 only.
  - Stream step t (t = 0..K+N-2) is visible in cycle C+1+t:
    - a lane i = A[i][t-i] when 0 ≤ t-i < K, else 8'h00.
    - b lane j = B[t-j][j] when 0 ≤ t-j < K, else 8'h00.
  - 8'h00 is E4M3 +0 and contributes a zero product in the PE.
  - a_edge and b_edge are 0 in every cycle outside the stream window.
  - tile_done is high in cycle C+K+N+(N-1)+PE_LATENCY only.
  - in_ready returns high the cycle after tile_done.
- Buffers are overwritten only during load. Contents during STREAM are stable.
- No arithmetic is performed on the data; bytes pass unmodified.
- Counters:
  - The beat counter is $clog2(N)+1 bits.
  - The step counter is sized for max(K+N-1, N-1+PE_LATENCY).
  - Counters saturate and never wrap within a tile.

Decomposition:
- Shared package tpu_pkg holds:
  - FP8_W=8, BF16_W=16, PE_LATENCY=3.
  - The feeder state enum {LOAD_A, LOAD_B, CLEAR, STREAM, DRAIN, DONE}.
  - The E4M3 zero constant 8'h00.
- One sub-module, fp8_tile_buffer (N x K bytes, write-by-beat, combinational skewed read by step t), instantiated twice: once for A, once for B.

Test Plan:
- Reset then idle, N=2, K=2 → in_ready=1 the cycle after rst→1. clear, busy, tile_done, a_edge and b_edge all 0.
- Load A rows {38,40}, {30,48} and B columns {38,38}, {40,30} back-to-back, last handshake at cycle L → clear at L+1. a_edge lanes (lane1,lane0):
  - L+2: (00,38)
  - L+3: (30,40)
  - L+4: (48,00)
  - then 0
- Same load, b_edge lanes (lane1,lane0):
  - L+2: (00,38)
  - L+3: (40,38)
  - L+4: (30,00)
  - tile_done high at L+9 only; busy high L+1..L+9.
- in_valid toggled 1-0-1 during load, plus in_valid=1 held during STREAM → only 4 handshakes counted. Extra beats are not stored; stream contents are unchanged.
- rst=0 at L+3 → next cycle all outputs 0 and state is LOAD_A. A fresh tile then completes with correct skew and a single tile_done pulse.
- Two tiles back-to-back → second tile's LOAD_A begins the cycle after the first tile_done. Second clear precedes second stream by exactly 1 cycle.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array front end: operand widths, PE pipeline depth,
// feeder state encoding and the E4M3 zero byte.
package tpu_pkg;

    localparam int unsigned FP8_W      = 8;
    localparam int unsigned BF16_W     = 16;
    localparam int unsigned PE_LATENCY = 3;

    // E4M3 +0: feeding it yields a zero product inside the PE.
    localparam logic [FP8_W-1:0] E4M3_ZERO = 8'h00;

    typedef enum logic [2:0] {
        StLoadA,
        StLoadB,
        StClear,
        StStream,
        StDrain,
        StDone
    } feeder_state_e;

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fp8_tile_buffer.sv
// N x K byte buffer, written one row (or column) per beat, read back as N skewed lanes:
// lane l at step t carries entry [l][t-l], or E4M3 zero outside the valid diagonal band.
module fp8_tile_buffer
    import tpu_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned K     = 2,
    parameter int unsigned AddrW = $clog2(N) + 1,
    parameter int unsigned StepW = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [AddrW-1:0]     waddr_i,
    input  logic [FP8_W*K-1:0]   wdata_i,
    input  logic [StepW-1:0]     step_i,
    output logic [FP8_W*N-1:0]   lanes_o
);

    logic [FP8_W-1:0] mem_q [N][K];

    // Beat write; reset discards any partially loaded tile.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int r = 0; r < int'(N); r++) begin
                for (int k = 0; k < int'(K); k++) begin
                    mem_q[r][k] <= E4M3_ZERO;
                end
            end
        end else if (we_i) begin
            for (int r = 0; r < int'(N); r++) begin
                if (int'(waddr_i) == r) begin
                    for (int k = 0; k < int'(K); k++) begin
                        mem_q[r][k] <= wdata_i[FP8_W*k +: FP8_W];
                    end
                end
            end
        end
    end

    // Skewed read: lane l picks element k when t == l + k, which is exactly one k or none.
    always_comb begin
        lanes_o = {N{E4M3_ZERO}};
        for (int l = 0; l < int'(N); l++) begin
            for (int k = 0; k < int'(K); k++) begin
                if (int'(step_i) == l + k) begin
                    lanes_o[FP8_W*l +: FP8_W] = mem_q[l][k];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Loads one FP8 A/B tile pair over valid/ready, then replays it diagonally skewed into the
// west and north edges of an N x N PE array, issuing the accumulator clear up front and
// flagging tile_done once the last PE result has settled.
module systolic_skew_feeder #(
    parameter int unsigned N          = 2,
    parameter int unsigned K          = 2,
    parameter int unsigned PE_LATENCY = tpu_pkg::PE_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [tpu_pkg::FP8_W*K-1:0]   in_data,
    output logic [tpu_pkg::FP8_W*N-1:0]   a_edge,
    output logic [tpu_pkg::FP8_W*N-1:0]   b_edge,
    output logic                          clear,
    output logic                          busy,
    output logic                          tile_done
);
    import tpu_pkg::*;

    localparam int unsigned BeatW     = $clog2(N) + 1;
    localparam int unsigned StreamLen = K + N - 1;
    localparam int unsigned DrainLen  = N - 1 + PE_LATENCY;
    localparam int unsigned StepMax   = max_u(StreamLen, DrainLen);
    localparam int unsigned StepW     = $clog2(StepMax + 1);
    localparam int unsigned LaneW     = FP8_W * N;

    feeder_state_e    state_q, state_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [StepW-1:0] step_q, step_d;

    logic             in_ready_q, in_ready_d;
    logic             clear_q, clear_d;
    logic             busy_q, busy_d;
    logic             tile_done_q, tile_done_d;
    logic [LaneW-1:0] a_edge_q, a_edge_d;
    logic [LaneW-1:0] b_edge_q, b_edge_d;

    logic             hs;
    logic             a_we, b_we;
    logic [LaneW-1:0] a_lanes, b_lanes;

    // in_ready_q is only ever high in the load states, so it alone qualifies a handshake.
    assign hs   = in_valid && in_ready_q;
    assign a_we = hs && (state_q == StLoadA);
    assign b_we = hs && (state_q == StLoadB);

    // Both buffers share the same skew rule: lane l reads [l][t-l] (A row l, B column l).
    fp8_tile_buffer #(
        .N     (N),
        .K     (K),
        .AddrW (BeatW),
        .StepW (StepW)
    ) u_a_buf (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (a_we),
        .waddr_i (beat_q),
        .wdata_i (in_data),
        .step_i  (step_d),
        .lanes_o (a_lanes)
    );

    fp8_tile_buffer #(
        .N     (N),
        .K     (K),
        .AddrW (BeatW),
        .StepW (StepW)
    ) u_b_buf (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (b_we),
        .waddr_i (beat_q),
        .wdata_i (in_data),
        .step_i  (step_d),
        .lanes_o (b_lanes)
    );

    // Phase sequencing; counters only advance below their terminal value, so they never wrap.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        step_d  = step_q;
        unique case (state_q)
            StLoadA: begin
                if (hs) begin
                    if (beat_q == BeatW'(N - 1)) begin
                        state_d = StLoadB;
                        beat_d  = '0;
                    end else if (beat_q < BeatW'(N - 1)) begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StLoadB: begin
                if (hs) begin
                    if (beat_q == BeatW'(N - 1)) begin
                        state_d = StClear;
                        beat_d  = '0;
                    end else if (beat_q < BeatW'(N - 1)) begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StClear: begin
                state_d = StStream;
                step_d  = '0;
            end
            StStream: begin
                if (step_q == StepW'(StreamLen - 1)) begin
                    state_d = StDrain;
                    step_d  = '0;
                end else if (step_q < StepW'(StreamLen - 1)) begin
                    step_d = step_q + 1'b1;
                end
            end
            StDrain: begin
                if (step_q == StepW'(DrainLen - 1)) begin
                    state_d = StDone;
                    step_d  = '0;
                end else if (step_q < StepW'(DrainLen - 1)) begin
                    step_d = step_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StLoadA;
                beat_d  = '0;
                step_d  = '0;
            end
            default: begin
                state_d = StLoadA;
                beat_d  = '0;
                step_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        in_ready_d  = (state_d == StLoadA) || (state_d == StLoadB);
        clear_d     = (state_d == StClear);
        busy_d      = (state_d == StClear) || (state_d == StStream) ||
                      (state_d == StDrain) || (state_d == StDone);
        tile_done_d = (state_d == StDone);
        a_edge_d    = {N{E4M3_ZERO}};
        b_edge_d    = {N{E4M3_ZERO}};
        if (state_d == StStream) begin
            a_edge_d = a_lanes;
            b_edge_d = b_lanes;
        end
    end

    // State, counters and registered outputs; reset aborts any tile in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StLoadA;
            beat_q      <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b0;
            a_edge_q    <= '0;
            b_edge_q    <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            clear_q     <= clear_d;
            busy_q      <= busy_d;
            tile_done_q <= tile_done_d;
            a_edge_q    <= a_edge_d;
            b_edge_q    <= b_edge_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign clear     = clear_q;
    assign busy      = busy_q;
    assign tile_done = tile_done_q;
    assign a_edge    = a_edge_q;
    assign b_edge    = b_edge_q;

endmodule
